// File: rtl/year_disp_pkg.sv
// Shared constants for the year display path: segment codes (active-low,
// {g,f,e,d,c,b,a}) and the digit-to-segment helper.
package year_disp_pkg;
  localparam int         DIGITS    = 4;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seg7_pair_decode.sv
// Splits a binary pair value (0-99) into tens/units segment codes; values
// above 99 show a dash on both digits.
module seg7_pair_decode
  import year_disp_pkg::*;
(
  input  logic [6:0] value,
  output logic [6:0] tens_seg,
  output logic [6:0] units_seg
);
  logic [3:0] tens_d;
  logic [3:0] units_d;

  always_comb begin
    tens_d    = 4'(value / 7'd10);
    units_d   = 4'(value % 7'd10);
    tens_seg  = SEG_DASH;
    units_seg = SEG_DASH;
    if (value <= 7'd99) begin
      tens_seg  = seg_code(tens_d);
      units_seg = seg_code(units_d);
    end
  end
endmodule

// File: rtl/year_seg_scan.sv
// Multiplexed 4-digit common-anode scanner for the year counter, with
// frame-boundary snapshot, anode guard interval and edit-pair blinking.
module year_seg_scan
  import year_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cnt_y_thousand_hundred,
  input  logic [6:0] cnt_y_ten_unit,
  input  logic       blink_hi,
  input  logic       blink_lo,
  output logic [3:0] an_n,
  output logic [6:0] seg_n
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [FW-1:0] frame_reg, frame_next;
  logic          phase_reg, phase_next;
  logic [6:0]    snap_hi_reg, snap_hi_next;
  logic [6:0]    snap_lo_reg, snap_lo_next;
  logic          load_pending_reg, load_pending_next;
  logic [6:0]    seg_reg, seg_next;
  logic [3:0]    an_reg, an_next;
  logic          tick;
  logic          frame_wrap;
  logic [3:0]    an_onecold;
  logic [3:0]    an_mask;
  logic [6:0]    digit_seg [DIGITS];

  // Decoders read the next-snapshot values so a boundary slot shows fresh data.
  seg7_pair_decode u_dec_lo (
    .value     (snap_lo_next),
    .tens_seg  (digit_seg[1]),
    .units_seg (digit_seg[0])
  );

  seg7_pair_decode u_dec_hi (
    .value     (snap_hi_next),
    .tens_seg  (digit_seg[3]),
    .units_seg (digit_seg[2])
  );

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
    assign an_onecold[gi] = (idx_next != 2'(gi));
  end

  assign an_mask = {{2{blink_hi & phase_next}}, {2{blink_lo & phase_next}}};

  always_comb begin
    tick              = (cnt_reg == CW'(REFRESH_DIV - 1));
    frame_wrap        = tick && (idx_reg == 2'd3);
    cnt_next          = tick ? '0 : cnt_reg + CW'(1);
    idx_next          = tick ? idx_reg + 2'd1 : idx_reg;
    frame_next        = frame_reg;
    phase_next        = phase_reg;
    snap_hi_next      = snap_hi_reg;
    snap_lo_next      = snap_lo_reg;
    load_pending_next = 1'b0;
    if (frame_wrap) begin
      if (frame_reg == FW'(BLINK_FRAMES - 1)) begin
        frame_next = '0;
        phase_next = ~phase_reg;
      end else begin
        frame_next = frame_reg + FW'(1);
      end
    end
    if (load_pending_reg || frame_wrap) begin
      snap_hi_next = cnt_y_thousand_hundred;
      snap_lo_next = cnt_y_ten_unit;
    end
    seg_next = (tick || load_pending_reg) ? digit_seg[idx_next] : seg_reg;
    an_next  = (int'(cnt_next) < GUARD) ? AN_OFF : (an_onecold | an_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg          <= '0;
      idx_reg          <= '0;
      frame_reg        <= '0;
      phase_reg        <= 1'b0;
      snap_hi_reg      <= '0;
      snap_lo_reg      <= '0;
      load_pending_reg <= 1'b1;
      seg_reg          <= SEG_BLANK;
      an_reg           <= AN_OFF;
    end else begin
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      frame_reg        <= frame_next;
      phase_reg        <= phase_next;
      snap_hi_reg      <= snap_hi_next;
      snap_lo_reg      <= snap_lo_next;
      load_pending_reg <= load_pending_next;
      seg_reg          <= seg_next;
      an_reg           <= an_next;
    end
  end

  assign an_n  = an_reg;
  assign seg_n = seg_reg;
endmodule

// File: doc/year_seg_scan.md
Name: year_seg_scan

Overview:
- Display-side reader for the year counter outputs; takes the two binary year fields (thousand/hundred pair, ten/unit pair, each 0-99) and drives a 4-digit multiplexed common-anode 7-segment display.
- Sequential: refresh divider, digit scanner, frame-boundary snapshot (no tearing mid-frame), anode guard interval, blink of the pair under edit.
- Sits between the year counter blocks and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); minimum 2
- GUARD, 2, cycles at the start of each digit slot with all anodes off (anti-ghosting); must be < REFRESH_DIV
- BLINK_FRAMES, 125, full 4-digit frames per blink half-period

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cnt_y_thousand_hundred  in  7  binary year high pair, valid 0-99
- cnt_y_ten_unit  in  7  binary year low pair, valid 0-99
- blink_hi  in  1  high pair under edit (tie to its enable)
- blink_lo  in  1  low pair under edit (tie to enable_cnt_y_ten_unit)
- an_n  out  4  anode select, active-low; bit0 = units digit, bit3 = thousands digit
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst=0, async): an_n=4'b1111, seg_n=7'b1111111, refresh counter=0, digit index=0, frame counter=0, blink_phase=0, snapshots=0, load_pending=1.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps; tick = (counter == REFRESH_DIV-1).
- Digit index: 2-bit, advances 0→1→2→3→0 on each tick edge. Index 0 = units, 1 = tens, 2 = hundreds, 3 = thousands.
- Snapshot:
  - Both inputs are latched into internal registers on the tick edge where the index goes 3→0.
  - They are also latched on the first clk edge after reset release (load_pending then clears).
  - Input changes between frame boundaries are not visible until the next boundary.
- Decode:
  - Pair value v ≤ 99: tens = v/10, units = v%10.
  - v in 100..127: both digits of that pair show a dash, seg_n=7'b0111111.
  - Active-low digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Outputs registered, 1-cycle latency:
  - On each tick edge, seg_n loads the code of the new index.
  - an_n is 4'b1111 for the first GUARD cycles of the slot (counter < GUARD), then drives the one-cold pattern for the index.
  - seg_n is stable for the whole slot.
- Blink:
  - The frame counter increments at every 3→0 index wrap, counting 0..BLINK_FRAMES-1; blink_phase toggles when it wraps.
  - When blink_phase=1, blink_lo forces an_n[1:0] high and blink_hi forces an_n[3:2] high; seg_n is unaffected.
  - When blink_phase=0, all digits are shown.
  - blink_hi and blink_lo are sampled every cycle, so deassertion un-blanks on the next cycle.
- Simultaneous events: a snapshot and the first digit-0 decode on the same tick edge use the NEW snapshot value (decode reads the next-snapshot mux).
- Reset mid-slot: outputs blank immediately; the scan restarts at index 0 with a full REFRESH_DIV slot.

Decomposition:
- Shared package year_disp_pkg:
  - SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111
  - digit code constants SEG_0..SEG_9
  - DIGITS=4, AN_OFF=4'b1111
- One sub-module, seg7_pair_decode (combinational): 7-bit value → {tens_seg, units_seg}, including dash handling; instantiated twice.

Test Plan (REFRESH_DIV=4, GUARD=1, BLINK_FRAMES=2):
- Reset release, inputs 20/24 → slots in order:
  - an_n=1110, seg_n=0011001 ("4")
  - an_n=1101, seg_n=0100100 ("2")
  - an_n=1011, seg_n=1000000 ("0")
  - an_n=0111, seg_n=0100100 ("2")
  - an_n=1111 during each slot's first cycle.
- Low pair changed 24→25 during the index-2 slot → remaining slots of that frame unchanged; next frame's units slot shows seg_n=0010010.
- Low pair=105 → both low digits show seg_n=0111111; high digits still decode normally.
- blink_lo=1 → an_n[1:0]=11 throughout frames 2-3, 6-7, …; normal in frames 0-1, 4-5; blink_hi digits unaffected.
- Low pair 99→0 at a frame boundary → units/tens go 0010000/0010000 → 1000000/1000000 in the next frame.
- rst pulled low mid-slot with an_n=1101 → an_n=1111, seg_n=1111111 without a clock edge; after release, scan resumes at index 0 showing the snapshot taken on the first edge.
